// File: rtl/btn_sw_reader_pkg.sv
// Shared constants for the button/switch read responder: register byte
// offsets, field widths and the release-event build switch.
// Optional feature macro: BTN_RELEASE_EVT_EN (release-event flags at 0x008[12:8]).
package btn_sw_reader_pkg;

    localparam logic [11:0] BTN_REG_SW  = 12'h000;
    localparam logic [11:0] BTN_REG_LVL = 12'h004;
    localparam logic [11:0] BTN_REG_EVT = 12'h008;
    localparam logic [11:0] BTN_REG_CNT = 12'h00C;

    // Low two address bits select a byte within a word and are ignored.
    localparam logic [11:0] BTN_ADDR_WORD_MASK = 12'hFFC;

    localparam int BTN_PRESS_CNT_W = 16;
    localparam int BTN_REL_LSB     = 8;

`ifdef BTN_RELEASE_EVT_EN
    localparam bit BTN_REL_EVT_ON = 1'b1;
`else
    localparam bit BTN_REL_EVT_ON = 1'b0;
`endif

    function automatic logic reg_hit(input logic [11:0] addr, input logic [11:0] offset);
        return (addr & BTN_ADDR_WORD_MASK) == offset;
    endfunction

endpackage

// File: rtl/btn_sw_reader_debounce.sv
// Single-bit input conditioner: two-flop synchroniser followed by a
// stable-time debounce counter. rise/fall are combinational and are high in
// the cycle whose closing edge changes level, so callers can capture the
// event on the same edge the level moves.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync_2 != level) && (cnt == CNT_LAST);
    assign rise   = accept && sync_2;
    assign fall   = accept && !sync_2;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_sw_reader.sv
// Read-only bus responder for the board buttons and switches. Switches are
// synchronised only; buttons are debounced and produce sticky read-to-clear
// press flags plus a wrapping 16-bit press counter.
// Optional feature macro: BTN_RELEASE_EVT_EN adds read-to-clear release flags.
module btn_sw_reader
    import btn_sw_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int N_BTN           = 5,
    parameter int N_SW            = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  button,
    input  logic [N_SW-1:0]   switches,
    input  logic [11:0]       addr,
    input  logic              rd_en,
    output logic [31:0]       rdata
);

    logic [N_SW-1:0]            sw_s1;
    logic [N_SW-1:0]            sw_q;
    logic [N_BTN-1:0]           level;
    logic [N_BTN-1:0]           rise;
    logic [N_BTN-1:0]           fall;
    logic [N_BTN-1:0]           press_flag;
    logic [N_BTN-1:0]           rel_flag;
    logic [BTN_PRESS_CNT_W-1:0] press_cnt;
    logic [BTN_PRESS_CNT_W-1:0] rise_cnt;
    logic                       evt_rd;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .din  (button[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign evt_rd = rd_en && reg_hit(addr, BTN_REG_EVT);

    // Switches are level inputs read by software; synchronise only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1 <= '0;
            sw_q  <= '0;
        end else begin
            sw_s1 <= switches;
            sw_q  <= sw_s1;
        end
    end

    // Number of buttons whose debounced level rises this cycle.
    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rise_cnt = rise_cnt + BTN_PRESS_CNT_W'(rise[i]);
        end
    end

    // Sticky press flags: the event read clears everything it returned,
    // and a rise on the same edge survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_flag <= '0;
        end else begin
            press_flag <= (evt_rd ? '0 : press_flag) | rise;
        end
    end

    // Press counter wraps naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_cnt <= '0;
        end else begin
            press_cnt <= press_cnt + rise_cnt;
        end
    end

`ifdef BTN_RELEASE_EVT_EN
    // Sticky release flags with the same clear/set-wins behaviour as presses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_flag <= '0;
        end else begin
            rel_flag <= (evt_rd ? '0 : rel_flag) | fall;
        end
    end
`else
    // No release storage in this build; fall edges are masked off.
    assign rel_flag = fall & {N_BTN{1'b0}};
`endif

    // Zero-wait-state read mux; unmapped offsets read zero.
    always_comb begin
        rdata = '0;
        if (reg_hit(addr, BTN_REG_SW)) begin
            rdata = 32'(sw_q);
        end else if (reg_hit(addr, BTN_REG_LVL)) begin
            rdata = 32'(level);
        end else if (reg_hit(addr, BTN_REG_EVT)) begin
            rdata = 32'(press_flag) | (32'(rel_flag) << BTN_REL_LSB);
        end else if (reg_hit(addr, BTN_REG_CNT)) begin
            rdata = 32'(press_cnt);
        end
    end

endmodule

// File: tb/tb_btn_sw_reader.sv
// Self-checking bench for btn_sw_reader with DEBOUNCE_CYCLES=4.
module tb_btn_sw_reader;

    localparam int DB = 4;

`ifdef BTN_RELEASE_EVT_EN
    localparam logic [31:0] REL_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] REL_MASK = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  button;
    logic [23:0] switches;
    logic [11:0] addr;
    logic        rd_en;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    btn_sw_reader #(
        .DEBOUNCE_CYCLES(DB),
        .N_BTN(5),
        .N_SW(24)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .switches(switches),
        .addr    (addr),
        .rd_en   (rd_en),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rel(input logic [4:0] m);
        return {19'b0, m, 8'b0} & REL_MASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drives one bus read, checks rdata before the
    // next posedge, and returns at the following negedge.
    task automatic bus_read(input logic [11:0] a, input logic rd, input logic [31:0] exp,
                            input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr  = a;
        rd_en = rd;
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag_q.pop_front(), rdata, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        button   = 5'h1F;
        switches = 24'hFF_FFFF;
        addr     = '0;
        rd_en    = 1'b0;
        cycles(2);

        // Reset holds everything at zero even with inputs active.
        bus_read(12'h000, 1'b0, 32'h0, "rst_sw");
        bus_read(12'h004, 1'b0, 32'h0, "rst_lvl");
        bus_read(12'h008, 1'b1, 32'h0, "rst_evt");
        bus_read(12'h00C, 1'b0, 32'h0, "rst_cnt");

        rst = 1'b1;
        bus_read(12'h000, 1'b0, 32'h0, "sw_lat0");
        bus_read(12'h000, 1'b0, 32'h0, "sw_lat1");
        bus_read(12'h000, 1'b0, 32'h00FF_FFFF, "sw_lat2");
        bus_read(12'h004, 1'b0, 32'h0, "lvl_lat3");
        bus_read(12'h004, 1'b0, 32'h0, "lvl_lat4");
        bus_read(12'h004, 1'b0, 32'h0, "lvl_lat5");
        bus_read(12'h004, 1'b0, 32'h1F, "lvl_lat6");
        bus_read(12'h008, 1'b0, 32'h1F, "evt_after_rst");
        bus_read(12'h007, 1'b0, 32'h1F, "lvl_byte_addr");
        bus_read(12'h010, 1'b1, 32'h0, "unmapped");
        bus_read(12'h00C, 1'b1, 32'h5, "cnt_five");
        bus_read(12'h008, 1'b0, 32'h1F, "evt_no_side_eff");
        bus_read(12'h008, 1'b1, 32'h1F, "evt_rd_all");
        bus_read(12'h008, 1'b0, 32'h0, "evt_cleared");

        button = 5'h00;
        cycles(8);
        bus_read(12'h004, 1'b0, 32'h0, "lvl_released");
        bus_read(12'h008, 1'b1, rel(5'h1F), "evt_rel_all");
        bus_read(12'h00C, 1'b0, 32'h5, "cnt_after_rel");

        // Glitch of DB-1 cycles is rejected.
        button = 5'h01;
        cycles(DB - 1);
        button = 5'h00;
        cycles(10);
        bus_read(12'h004, 1'b0, 32'h0, "glitch_lvl");
        bus_read(12'h008, 1'b0, 32'h0, "glitch_evt");
        bus_read(12'h00C, 1'b0, 32'h5, "glitch_cnt");

        // Read-to-clear of a single press.
        button = 5'h04;
        cycles(8);
        bus_read(12'h008, 1'b0, 32'h04, "r2c_peek");
        bus_read(12'h008, 1'b1, 32'h04, "r2c_read");
        bus_read(12'h008, 1'b0, 32'h00, "r2c_after");
        bus_read(12'h00C, 1'b0, 32'h6, "r2c_cnt");
        button = 5'h00;
        cycles(8);
        bus_read(12'h008, 1'b1, rel(5'h04), "r2c_rel");

        // Set wins: button[1] rises on the edge of the clearing read.
        button = 5'h04;
        cycles(8);
        button = 5'h06;
        cycles(DB + 1);
        bus_read(12'h008, 1'b1, 32'h04, "setwin_read");
        bus_read(12'h008, 1'b0, 32'h02, "setwin_after");
        bus_read(12'h00C, 1'b0, 32'h8, "setwin_cnt");
        button = 5'h00;
        cycles(8);
        bus_read(12'h008, 1'b1, 32'h02 | rel(5'h06), "setwin_clear");

        // Counter wrap from 0xFFFF with two simultaneous presses.
        force dut.press_cnt = 16'hFFFF;
        #1;
        release dut.press_cnt;
        @(negedge clk);
        bus_read(12'h00C, 1'b0, 32'hFFFF, "wrap_preload");
        button = 5'h09;
        cycles(8);
        bus_read(12'h00C, 1'b0, 32'h0001, "wrap_cnt");
        bus_read(12'h008, 1'b0, 32'h09, "wrap_evt");
        button = 5'h00;
        cycles(8);
        bus_read(12'h008, 1'b1, 32'h09 | rel(5'h09), "wrap_clear");

        // Press and release of button[4].
        button = 5'h10;
        cycles(8);
        button = 5'h00;
        cycles(8);
        bus_read(12'h008, 1'b1, 32'h10 | rel(5'h10), "relevt_read");
        bus_read(12'h008, 1'b0, 32'h0, "relevt_after");

        // Reset mid-debounce with the button held: exactly one press afterwards.
        button = 5'h08;
        cycles(4);
        rst = 1'b0;
        bus_read(12'h00C, 1'b0, 32'h0, "midrst_cnt0");
        bus_read(12'h004, 1'b0, 32'h0, "midrst_lvl0");
        rst = 1'b1;
        cycles(DB + 1);
        bus_read(12'h004, 1'b0, 32'h0, "midrst_lvl_pre");
        bus_read(12'h004, 1'b0, 32'h08, "midrst_lvl");
        bus_read(12'h008, 1'b0, 32'h08, "midrst_evt");
        bus_read(12'h00C, 1'b0, 32'h1, "midrst_cnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
